mmio_peripheral: RTL and testbench
==================================

# mmio_peripheral

Memory-mapped peripheral block on the data-memory bus of the pipelined CPU, downstream of the MEM stage. It is selected by data address and holds four kinds of state: the LED register, a scanned 4-digit hex seven-segment display, a reloadable timer with an interrupt flag, and a free-running SysTick counter. Reads are combinational so the MEM stage can merge `rdata` into its load path. Writes commit on the clock edge.

## Interface
- `BASE_ADDR`, 32'h40000000, base of the 6-word register window.
- `SCAN_DIV`, 100000, clock cycles each display digit is driven (≥2).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  32  data address from the MEM stage (ALU output).
- `wdata`  in  32  store data.
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `hit`  out  1  `addr` lies in the register window.
- `rdata`  out  32  read data; 0 when `!hit` or `!MemRead`.
- `leds`  out  8  LED drive.
- `bcd7`  out  8  {dp,g,f,e,d,c,b,a}, active-high.
- `an`  out  4  digit enables, active-low one-hot.
- `irq`  out  1  timer interrupt request.

## Operation
- Decode: `hit` = (`addr[31:5]` == `BASE_ADDR[31:5]`) && (`addr[4:2]` ≤ 5). `addr[1:0]` is ignored. Register writes occur only when `MemWrite && hit`.
- Register offsets:
  - +0x00 TH: 32-bit reload, RW.
  - +0x04 TL: 32-bit counter, RW.
  - +0x08 TCON:
    - bit0 EN, RW.
    - bit1 IE, RW.
    - bit2 ST, status: set by hardware, cleared by writing 0, writing 1 has no effect.
    - Other bits read 0.
  - +0x0C LED:
    - Bits [7:0] RW; `leds` = LED.
    - Upper bits read 0.
  - +0x10 DISP:
    - [15:0] four hex digits, digit i = bits [4i+3:4i].
    - [19:16] decimal point per digit.
    - [20] BLANK.
    - Upper bits read 0.
  - +0x14 SYSTICK: increments every cycle, read-only; writes are ignored.
- Timer, when EN=1:
  - If TL != 32'hFFFFFFFF: TL ← TL+1.
  - If TL == 32'hFFFFFFFF: TL ← TH, and ST ← 1 if IE=1.
  - When EN=0, TL holds.
- `irq` = IE & ST, combinational from the registers.
- Display scan:
  - Counter `scan_cnt` runs 0..SCAN_DIV-1. On wrap, `digit_idx` (2 bits) increments mod 4.
  - Each cycle, registered outputs load `an` ← ~(1<<digit_idx), `bcd7[6:0]` ← hexseg(digit nibble), `bcd7[7]` ← DISP[16+digit_idx].
  - When BLANK=1: `an` ← 4'hF, `bcd7` ← 0.
- Hex segment map: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Boundary cases:
  - Software write to TL in the same cycle as an increment or reload: the write wins, and ST is not set that cycle.
  - TCON write clearing ST in the same cycle as a hardware set: the hardware set wins, ST=1. EN/IE still take the written values.
  - Reads and writes outside the window: `hit`=0, no state change.
  - SYSTICK wraps from 32'hFFFFFFFF to 0.

## Timing
- Reset (synchronous) sets every register to 0: TH, TL, TCON, LED, DISP, SYSTICK, `scan_cnt`, `digit_idx`.
- Output values during and at reset: `leds`=0, `bcd7`=0, `an`=4'hF, `irq`=0.
- First edge after reset deassertion: `an`=4'b1110, `bcd7`=8'h3F (digit0=0).
- Write latency: a register written at edge N shows its new value on `rdata` after edge N. `leds` changes after edge N. `bcd7`/`an` reflect the new DISP after edge N+1, because of the output register.
- A read in the same cycle as a write to that register returns the old value.
- SYSTICK read at cycle k returns k cycles counted since reset release.
- Each digit is driven for exactly SCAN_DIV consecutive cycles, in the order an=1110, 1101, 1011, 0111, then repeating.
- Reset asserted mid-scan or mid-count: all state returns to reset values on that edge.

## Test plan
- Reset → `leds`=0, `an`=4'hF, `bcd7`=0, `irq`=0. Reads of all six registers return 0. One cycle after release, `an`=1110 and `bcd7`=3F.
- Write 0x4000000C ← 0xFFFFFFA5 → `leds`=A5 next cycle; readback 0x000000A5. Write 0x40000018 ← 1 → `hit`=0, `rdata`=0, no state change.
- TH←FFFFFFFD, TL←FFFFFFFE, TCON←3 → TL reads FFFFFFFF, then FFFFFFFD with ST=1 and `irq`=1. TCON←3 → ST=0, `irq`=0. TCON←7 with ST=0 → ST stays 0.
- TL at FFFFFFFF with EN=IE=1, and a write TCON←3 on the overflow edge → ST=1, `irq`=1. Separately, a TL←5 write on an overflow edge → TL=5, ST unchanged.
- SCAN_DIV=4, DISP←0x0001A3F0 → digit outputs, each held 4 cycles:
  - an=1110, bcd7=BF (dp on).
  - an=1101, bcd7=71.
  - an=1011, bcd7=4F.
  - an=0111, bcd7=77.
  - Then repeat. DISP←0x00100000 → `an`=F, `bcd7`=0.
- Two SYSTICK reads 10 cycles apart → difference 10. A write to SYSTICK does not alter the count.

Source files
------------

// File: rtl/mmio_peripheral.sv
// mmio_peripheral: memory-mapped timer, SysTick, LED register and scanned
// 4-digit hex seven-segment display on the CPU data bus; reads are combinational.
module mmio_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int unsigned SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [7:0]  leds,
  output logic [7:0]  bcd7,
  output logic [3:0]  an,
  output logic        irq
);
  localparam int unsigned   CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 32'd1);

  function automatic logic [6:0] hexseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [31:0]   th_q, th_d, tl_q, tl_d, systick_q, systick_d;
  logic          en_q, en_d, ie_q, ie_d, st_q, st_d;
  logic [7:0]    led_q, led_d, bcd7_q, bcd7_d;
  logic [20:0]   disp_q, disp_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [3:0]    an_q, an_d, dp_vec_s;
  logic [2:0]    reg_sel_s;
  logic          hit_s, wr_en_s, hw_set_s;

  // Address decode and combinational read mux for the MEM-stage load path.
  always_comb begin
    reg_sel_s = addr[4:2];
    hit_s     = (addr[31:5] == BASE_ADDR[31:5]) && (reg_sel_s <= 3'd5);
    wr_en_s   = MemWrite && hit_s;
    rdata     = 32'd0;
    if (hit_s && MemRead) begin
      case (reg_sel_s)
        3'd0:    rdata = th_q;
        3'd1:    rdata = tl_q;
        3'd2:    rdata = {29'd0, st_q, ie_q, en_q};
        3'd3:    rdata = {24'd0, led_q};
        3'd4:    rdata = {11'd0, disp_q};
        3'd5:    rdata = systick_q;
        default: rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // Next-state logic: timer, software writes, SysTick and display scan.
  always_comb begin
    th_d        = th_q;
    tl_d        = tl_q;
    en_d        = en_q;
    ie_d        = ie_q;
    st_d        = st_q;
    led_d       = led_q;
    disp_d      = disp_q;
    systick_d   = systick_q + 32'd1;
    hw_set_s    = 1'b0;
    scan_cnt_d  = scan_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    digit_idx_d = digit_idx_q;
    dp_vec_s    = disp_q[19:16];

    if (en_q) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d     = th_q;
        hw_set_s = ie_q;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end else begin
      tl_d = tl_q;
    end

    // A software TL write overrides the hardware update and suppresses its ST set.
    if (wr_en_s) begin
      case (reg_sel_s)
        3'd0: th_d = wdata;
        3'd1: begin
          tl_d     = wdata;
          hw_set_s = 1'b0;
        end
        3'd2: begin
          en_d = wdata[0];
          ie_d = wdata[1];
          st_d = st_q & wdata[2];
        end
        3'd3:    led_d  = wdata[7:0];
        3'd4:    disp_d = wdata[20:0];
        default: th_d   = th_q;
      endcase
    end else begin
      th_d = th_q;
    end

    if (hw_set_s) begin
      st_d = 1'b1;
    end else begin
      st_d = st_d;
    end

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = {CW{1'b0}};
      digit_idx_d = digit_idx_q + 2'd1;
    end else begin
      digit_idx_d = digit_idx_q;
    end

    if (disp_q[20]) begin
      an_d   = 4'hF;
      bcd7_d = 8'h00;
    end else begin
      an_d   = ~(4'b0001 << digit_idx_q);
      bcd7_d = {dp_vec_s[digit_idx_q], hexseg(disp_q[{digit_idx_q, 2'b00} +: 4])};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q        <= 32'd0;
      tl_q        <= 32'd0;
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      st_q        <= 1'b0;
      led_q       <= 8'd0;
      disp_q      <= 21'd0;
      systick_q   <= 32'd0;
      scan_cnt_q  <= {CW{1'b0}};
      digit_idx_q <= 2'd0;
      an_q        <= 4'hF;
      bcd7_q      <= 8'h00;
    end else begin
      th_q        <= th_d;
      tl_q        <= tl_d;
      en_q        <= en_d;
      ie_q        <= ie_d;
      st_q        <= st_d;
      led_q       <= led_d;
      disp_q      <= disp_d;
      systick_q   <= systick_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      bcd7_q      <= bcd7_d;
    end
  end

  assign hit  = hit_s;
  assign leds = led_q;
  assign bcd7 = bcd7_q;
  assign an   = an_q;
  assign irq  = ie_q & st_q;

endmodule

// File: tb/tb_mmio_peripheral.sv
// Self-checking bench for mmio_peripheral: directed test-plan steps followed by
// random bus traffic, all checked against a register-array reference model.
module tb_mmio_peripheral;
  localparam logic [31:0] BASE = 32'h40000000;
  localparam int          SDIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        MemRead, MemWrite, hit, irq;
  logic [7:0]  leds, bcd7;
  logic [3:0]  an;

  mmio_peripheral #(.BASE_ADDR(BASE), .SCAN_DIV(SDIV)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .MemRead(MemRead),
    .MemWrite(MemWrite), .hit(hit), .rdata(rdata), .leds(leds), .bcd7(bcd7),
    .an(an), .irq(irq)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_reg [6];     // TH, TL, TCON, LED, DISP, SYSTICK as software sees them
  logic [31:0] m_disp_out;    // DISP value the output register sampled at the last edge
  int          cyc;           // edges since reset release
  logic [6:0]  seg_tab [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return (a[31:5] == BASE[31:5]) && (a[4:2] <= 3'd5);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic rd);
    if (rd && in_win(a)) return m_reg[a[4:2]];
    return 32'd0;
  endfunction

  task automatic model_edge(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                            input logic wr);
    logic [31:0] nr [6];
    logic        set;
    m_disp_out = m_reg[4];
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 32'd0;
      cyc = 0;
      return;
    end
    nr    = m_reg;
    nr[5] = m_reg[5] + 32'd1;
    set   = 1'b0;
    if (m_reg[2][0]) begin
      if (m_reg[1] == 32'hFFFF_FFFF) begin
        nr[1] = m_reg[0];
        set   = m_reg[2][1];
      end else begin
        nr[1] = m_reg[1] + 32'd1;
      end
    end
    if (wr && in_win(a)) begin
      case (a[4:2])
        3'd0: nr[0] = wd;
        3'd1: begin nr[1] = wd; set = 1'b0; end
        3'd2: nr[2] = {29'd0, m_reg[2][2] & wd[2], wd[1:0]};
        3'd3: nr[3] = {24'd0, wd[7:0]};
        3'd4: nr[4] = {11'd0, wd[20:0]};
        default: ;
      endcase
    end
    if (set) nr[2][2] = 1'b1;
    m_reg = nr;
    cyc++;
  endtask

  task automatic check_outputs();
    int         d;
    logic [3:0] ea;
    logic [7:0] eb;
    check("leds", 32'(leds), 32'(m_reg[3][7:0]));
    check("irq", 32'(irq), 32'(m_reg[2][1] & m_reg[2][2]));
    if (cyc == 0 || m_disp_out[20]) begin
      ea = 4'hF;
      eb = 8'h00;
    end else begin
      d  = ((cyc - 1) / SDIV) % 4;
      ea = ~(4'b0001 << d);
      eb = {m_disp_out[16 + d], seg_tab[m_disp_out[4*d +: 4]]};
    end
    check("an", 32'(an), 32'(ea));
    check("bcd7", 32'(bcd7), 32'(eb));
  endtask

  task automatic do_op(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr);
    reset = rst; addr = a; wdata = wd; MemRead = rd; MemWrite = wr;
    #1;
    check("hit", 32'(hit), 32'(in_win(a)));
    check("rdata", rdata, exp_rd(a, rd));
    model_edge(rst, a, wd, wr);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    do_op(1'b0, 32'h0000_0000, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    addr = a; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
    v = rdata;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    peek(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    logic [31:0] s1, s2, a, wd;
    logic [3:0]  prev_an;
    logic        found;
    logic [3:0]  exp_an [4];
    logic [7:0]  exp_b7 [4];
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_b7  = '{8'hBF, 8'h71, 8'h4F, 8'h77};

    reset = 1'b1; addr = 32'd0; wdata = 32'd0; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    foreach (m_reg[i]) m_reg[i] = 32'd0;
    m_disp_out = 32'd0;
    cyc = 0;

    // Reset state: outputs idle and every register reads zero.
    for (int i = 0; i < 6; i++) begin
      do_op(1'b1, BASE + 32'(4 * i), 32'd0, 1'b1, 1'b0);
      check_rd("reset_read", BASE + 32'(4 * i), 32'd0);
    end
    check("reset_an", 32'(an), 32'h0000_000F);
    check("reset_bcd7", 32'(bcd7), 32'd0);
    idle();
    check("first_an", 32'(an), 32'h0000_000E);
    check("first_bcd7", 32'(bcd7), 32'h0000_003F);

    // LED write and out-of-window access.
    do_op(1'b0, BASE + 32'h0C, 32'hFFFF_FFA5, 1'b0, 1'b1);
    check("leds_a5", 32'(leds), 32'h0000_00A5);
    check_rd("led_readback", BASE + 32'h0C, 32'h0000_00A5);
    do_op(1'b0, BASE + 32'h18, 32'd1, 1'b1, 1'b1);
    check("oow_hit", 32'(hit), 32'd0);
    check_rd("led_unchanged", BASE + 32'h0C, 32'h0000_00A5);

    // Timer overflow, reload and ST/irq behaviour.
    do_op(1'b0, BASE + 32'h00, 32'hFFFF_FFFD, 1'b0, 1'b1);
    do_op(1'b0, BASE + 32'h04, 32'hFFFF_FFFE, 1'b0, 1'b1);
    do_op(1'b0, BASE + 32'h08, 32'd3, 1'b0, 1'b1);
    check_rd("tl_hold", BASE + 32'h04, 32'hFFFF_FFFE);
    idle();
    check_rd("tl_max", BASE + 32'h04, 32'hFFFF_FFFF);
    idle();
    check_rd("tl_reload", BASE + 32'h04, 32'hFFFF_FFFD);
    check_rd("tcon_st", BASE + 32'h08, 32'd7);
    check("irq_set", 32'(irq), 32'd1);
    do_op(1'b0, BASE + 32'h08, 32'd3, 1'b0, 1'b1);
    check("irq_clr", 32'(irq), 32'd0);
    do_op(1'b0, BASE + 32'h08, 32'd7, 1'b0, 1'b1);
    check_rd("st_w1_noeffect", BASE + 32'h08, 32'd3);
    do_op(1'b0, BASE + 32'h08, 32'd3, 1'b0, 1'b1);   // lands on the overflow edge
    check_rd("st_hw_wins", BASE + 32'h08, 32'd7);
    check("irq_hw_wins", 32'(irq), 32'd1);
    do_op(1'b0, BASE + 32'h08, 32'd3, 1'b0, 1'b1);
    idle();
    check_rd("tl_max2", BASE + 32'h04, 32'hFFFF_FFFF);
    do_op(1'b0, BASE + 32'h04, 32'd5, 1'b0, 1'b1);   // TL write on the overflow edge
    check_rd("tl_write_wins", BASE + 32'h04, 32'd5);
    check_rd("st_not_set", BASE + 32'h08, 32'd3);
    do_op(1'b0, BASE + 32'h08, 32'd0, 1'b0, 1'b1);

    // Display scan order, hold time and blanking.
    do_op(1'b0, BASE + 32'h10, 32'h0001_A3F0, 1'b0, 1'b1);
    idle();
    prev_an = an;
    found   = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      idle();
      if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
      else prev_an = an;
    end
    check("scan_sync", 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < 20; k++) begin
        check("scan_an", 32'(an), 32'(exp_an[(k / SDIV) % 4]));
        check("scan_bcd7", 32'(bcd7), 32'(exp_b7[(k / SDIV) % 4]));
        idle();
      end
    end
    do_op(1'b0, BASE + 32'h10, 32'h0010_0000, 1'b0, 1'b1);
    idle();
    check("blank_an", 32'(an), 32'h0000_000F);
    check("blank_bcd7", 32'(bcd7), 32'd0);

    // SYSTICK spacing and write immunity.
    peek(BASE + 32'h14, s1);
    repeat (10) do_op(1'b0, BASE + 32'h14, 32'd0, 1'b1, 1'b0);
    peek(BASE + 32'h14, s2);
    check("systick_diff", s2 - s1, 32'd10);
    peek(BASE + 32'h14, s1);
    do_op(1'b0, BASE + 32'h14, 32'h1234_5678, 1'b1, 1'b1);
    peek(BASE + 32'h14, s2);
    check("systick_wr_ignored", s2, s1 + 32'd1);

    // Reset mid-count returns everything to zero.
    do_op(1'b0, BASE + 32'h08, 32'd3, 1'b0, 1'b1);
    do_op(1'b1, BASE + 32'h0C, 32'h0000_00FF, 1'b1, 1'b1);
    check_rd("midreset_tcon", BASE + 32'h08, 32'd0);
    check_rd("midreset_systick", BASE + 32'h14, 32'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE + 32'h20 + 32'($urandom_range(0, 31));
        default: a = {BASE[31:5], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      endcase
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if (a[4:2] == 3'd2 && $urandom_range(0, 1) == 1) wd[1:0] = 2'b11;
      do_op(($urandom_range(0, 99) == 0), a, wd, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
